// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: opcode encodings, bus widths, FSM state
// encodings and small opcode-decode helpers.
package mem_access_pkg;

    typedef logic [7:0]  alu_op_t;
    typedef logic [31:0] reg_t;
    typedef logic [4:0]  reg_addr_t;

    localparam logic      RST_ENABLE = 1'b1;
    localparam reg_t      ZERO_WORD  = 32'h0000_0000;
    localparam reg_addr_t ZERO_REG   = 5'd0;

    localparam alu_op_t ME_NOP_OP = 8'h00;
    localparam alu_op_t ME_LB_OP  = 8'h20;
    localparam alu_op_t ME_LH_OP  = 8'h21;
    localparam alu_op_t ME_LW_OP  = 8'h22;
    localparam alu_op_t ME_LBU_OP = 8'h23;
    localparam alu_op_t ME_LHU_OP = 8'h24;
    localparam alu_op_t ME_SB_OP  = 8'h28;
    localparam alu_op_t ME_SH_OP  = 8'h29;
    localparam alu_op_t ME_SW_OP  = 8'h2A;

    localparam logic [1:0] ME_ST_IDLE   = 2'd0;
    localparam logic [1:0] ME_ST_ACCESS = 2'd1;
    localparam logic [1:0] ME_ST_DONE   = 2'd2;

    function automatic logic is_mem_op(input alu_op_t op);
        case (op)
            ME_LB_OP, ME_LH_OP, ME_LW_OP, ME_LBU_OP, ME_LHU_OP,
            ME_SB_OP, ME_SH_OP, ME_SW_OP: is_mem_op = 1'b1;
            default:                      is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input alu_op_t op);
        case (op)
            ME_SB_OP, ME_SH_OP, ME_SW_OP: is_store_op = 1'b1;
            default:                      is_store_op = 1'b0;
        endcase
    endfunction

    // Index of the final byte of the transaction (byte count minus one).
    function automatic logic [1:0] last_byte_idx(input alu_op_t op);
        case (op)
            ME_LB_OP, ME_LBU_OP, ME_SB_OP: last_byte_idx = 2'd0;
            ME_LH_OP, ME_LHU_OP, ME_SH_OP: last_byte_idx = 2'd1;
            default:                       last_byte_idx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ld_ext.sv
// Load result formatting: sign- or zero-extends the assembled little-endian
// byte buffer according to the load opcode.
module mem_ld_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] ld_buf_i,
    input  logic [7:0]  op_i,
    output logic [31:0] data_o
);

    // Select width and extension from the opcode.
    always_comb begin
        data_o = ld_buf_i;
        case (op_i)
            ME_LB_OP:  data_o = {{24{ld_buf_i[7]}}, ld_buf_i[7:0]};
            ME_LBU_OP: data_o = {24'h00_0000, ld_buf_i[7:0]};
            ME_LH_OP:  data_o = {{16{ld_buf_i[15]}}, ld_buf_i[15:0]};
            ME_LHU_OP: data_o = {16'h0000, ld_buf_i[15:0]};
            ME_LW_OP:  data_o = ld_buf_i;
            default:   data_o = ld_buf_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: passes non-memory ops through and runs loads/stores as byte-serial
// little-endian transactions on an 8-bit RAM port, stalling the pipeline meanwhile.
// Optional performance counters are built when MEM_PERF_CNT_EN is defined.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MEM_PERF_CNT_EN
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_memop_cnt_o,
`endif
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       mem_addr_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stall_req_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o,
    input  logic              ram_ready_i,
    input  logic [7:0]        ram_rdata_i
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [7:0]        op_q, op_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       ld_res_s;

    mem_ld_ext u_ld_ext (
        .ld_buf_i (buf_q),
        .op_i     (op_q),
        .data_o   (ld_res_s)
    );

    // Transaction FSM next-state, byte counter and load assembly.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        buf_d   = buf_q;
        case (state_q)
            ME_ST_IDLE: begin
                if (is_mem_op(aluop_i)) begin
                    state_d = ME_ST_ACCESS;
                    k_d     = 2'd0;
                    addr_d  = mem_addr_i[ADDR_W-1:0];
                    data_d  = wdata_i;
                    op_d    = aluop_i;
                    buf_d   = ZERO_WORD;
                end else begin
                    state_d = ME_ST_IDLE;
                end
            end
            ME_ST_ACCESS: begin
                if (ram_ready_i) begin
                    if (!is_store_op(op_q)) begin
                        buf_d[{k_q, 3'b000} +: 8] = ram_rdata_i;
                    end else begin
                        buf_d = buf_q;
                    end
                    k_d = k_q + 2'd1;
                    if (k_q == last_byte_idx(op_q)) begin
                        state_d = ME_ST_DONE;
                    end else begin
                        state_d = ME_ST_ACCESS;
                    end
                end else begin
                    state_d = ME_ST_ACCESS;
                end
            end
            ME_ST_DONE: begin
                state_d = ME_ST_IDLE;
                k_d     = 2'd0;
            end
            default: begin
                state_d = ME_ST_IDLE;
                k_d     = 2'd0;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-transaction aborts it.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= ME_ST_IDLE;
            k_q     <= 2'd0;
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= ZERO_WORD;
            op_q    <= ME_NOP_OP;
            buf_q   <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            buf_q   <= buf_d;
        end
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        wd_o        = ZERO_REG;
        wreg_o      = 1'b0;
        wdata_o     = ZERO_WORD;
        stall_req_o = 1'b0;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = {ADDR_W{1'b0}};
        ram_wdata_o = 8'h00;
        if (rst == RST_ENABLE) begin
            stall_req_o = 1'b0;
        end else begin
            case (state_q)
                ME_ST_IDLE: begin
                    if (is_mem_op(aluop_i)) begin
                        stall_req_o = 1'b1;
                    end else begin
                        wd_o = wd_i;
                        if (wd_i != ZERO_REG) begin
                            wreg_o  = wreg_i;
                            wdata_o = wdata_i;
                        end else begin
                            wreg_o  = 1'b0;
                        end
                    end
                end
                ME_ST_ACCESS: begin
                    stall_req_o = 1'b1;
                    ram_req_o   = 1'b1;
                    ram_we_o    = is_store_op(op_q);
                    ram_addr_o  = addr_q + {{(ADDR_W-2){1'b0}}, k_q};
                    ram_wdata_o = data_q[{k_q, 3'b000} +: 8];
                end
                ME_ST_DONE: begin
                    wd_o = wd_i;
                    if (!is_store_op(op_q) && (wd_i != ZERO_REG)) begin
                        wreg_o  = wreg_i;
                        wdata_o = ld_res_s;
                    end else begin
                        wreg_o  = 1'b0;
                    end
                end
                default: begin
                    stall_req_o = 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] memop_cnt_q;

    // Free-running, wrapping event counters.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            stall_cnt_q <= 32'd0;
            memop_cnt_q <= 32'd0;
        end else begin
            if (stall_req_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (state_q == ME_ST_DONE) begin
                memop_cnt_q <= memop_cnt_q + 32'd1;
            end else begin
                memop_cnt_q <= memop_cnt_q;
            end
        end
    end

    assign perf_stall_cnt_o = (rst == RST_ENABLE) ? 32'd0 : stall_cnt_q;
    assign perf_memop_cnt_o = (rst == RST_ENABLE) ? 32'd0 : memop_cnt_q;
`endif

endmodule
